// File: rtl/sifh_pkg.sv
// Shared SiFH definitions: parameter defaults matching parametersSiFH.vh,
// the sequencer state type and an index-width helper.
package sifh_pkg;

    localparam int SIFH_NP        = 10;
    localparam int SIFH_PIXEL_NUM = 3;
    localparam int SIFH_ACQ_NUM   = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ACQ,
        S_STREAM,
        S_GAP,
        S_DONE
    } seq_state_e;

    // Width of an index over n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/acq_fifo2.sv
// Two-entry acquisition buffer; head is the oldest entry, flush empties it.
module acq_fifo2 #(
    parameter int W = 30
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] e0_q, e0_d;
    logic [W-1:0] e1_q, e1_d;
    logic [1:0]   cnt_q, cnt_d;

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) e0_d = din;
                    else               e1_d = din;
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    e0_d  = e1_q;
                    cnt_d = cnt_q - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop: the new word lands behind whatever survives the pop.
                    if (cnt_q == 2'd1) begin
                        e0_d = din;
                    end else begin
                        e0_d = e1_q;
                        e1_d = din;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= '0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign head  = e0_q;
    assign count = cnt_q;

endmodule

// File: rtl/roughdata_sequencer.sv
// Serialises buffered per-pixel rough timestamps toward the histogram builder,
// one frame of ACQ_NUM acquisitions per start, with GAP_CYCLES idle between acquisitions.
module roughdata_sequencer
    import sifh_pkg::*;
#(
    parameter int NP         = SIFH_NP,
    parameter int PIXEL_NUM  = SIFH_PIXEL_NUM,
    parameter int ACQ_NUM    = SIFH_ACQ_NUM,
    parameter int GAP_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        res,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        acq_valid,
    input  logic [PIXEL_NUM*NP-1:0]     acq_data,
    output logic                        acq_ready,
    output logic                        wrEn,
    output logic [NP-1:0]               data,
    output logic [idx_w(PIXEL_NUM)-1:0] pix_idx,
    output logic [idx_w(ACQ_NUM)-1:0]   acq_idx,
    output logic                        busy,
    output logic                        frame_done
);

    localparam int PW = idx_w(PIXEL_NUM);
    localparam int AW = idx_w(ACQ_NUM);
    localparam int CW = idx_w(ACQ_NUM + 1);
    localparam int GW = idx_w(GAP_CYCLES);

    seq_state_e    state_q, state_d;
    logic          wr_en_q, wr_en_d;
    logic [NP-1:0] data_q, data_d;
    logic [PW-1:0] pix_idx_q, pix_idx_d;
    logic [AW-1:0] acq_idx_q, acq_idx_d;
    logic [CW-1:0] acc_cnt_q, acc_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          frame_done_q, frame_done_d;

    logic                    push, pop, flush;
    logic [1:0]              fifo_count;
    logic [PIXEL_NUM*NP-1:0] head;
    logic [NP-1:0]           head_pix [PIXEL_NUM];
    logic                    emit;
    logic [PW-1:0]           emit_pix;
    logic                    last_pix, last_acq, buf_nonempty;

    acq_fifo2 #(.W(PIXEL_NUM*NP)) u_fifo (
        .clk   (clk),
        .rst   (res),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   (acq_data),
        .head  (head),
        .count (fifo_count)
    );

    always_comb begin
        for (int unsigned p = 0; p < PIXEL_NUM; p++) head_pix[p] = head[p*NP +: NP];
    end

    assign busy         = (state_q != S_IDLE);
    assign acq_ready    = busy && (state_q != S_DONE) && (fifo_count < 2'd2)
                          && (acc_cnt_q < CW'(ACQ_NUM));
    assign push         = acq_valid && acq_ready;
    assign buf_nonempty = (fifo_count != 2'd0);
    assign last_pix     = (pix_idx_q == PW'(PIXEL_NUM - 1));
    assign last_acq     = (acq_idx_q == AW'(ACQ_NUM - 1));

    // The entry is popped as its last pixel is registered, so by the time that
    // pixel is on the outputs the head already holds the next acquisition.
    always_comb begin
        state_d      = state_q;
        wr_en_d      = 1'b0;
        data_d       = '0;
        pix_idx_d    = '0;
        acq_idx_d    = acq_idx_q;
        acc_cnt_d    = acc_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        frame_done_d = 1'b0;
        emit         = 1'b0;
        emit_pix     = '0;
        pop          = 1'b0;
        flush        = 1'b0;

        if (push) acc_cnt_d = acc_cnt_q + 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_WAIT_ACQ;
                    acq_idx_d = '0;
                    acc_cnt_d = '0;
                end
            end
            S_WAIT_ACQ: begin
                if (buf_nonempty) begin
                    state_d = S_STREAM;
                    emit    = 1'b1;
                end
            end
            S_STREAM: begin
                if (!last_pix) begin
                    emit     = 1'b1;
                    emit_pix = pix_idx_q + 1'b1;
                end else begin
                    acq_idx_d = acq_idx_q + 1'b1;
                    if (last_acq) begin
                        state_d      = S_DONE;
                        frame_done_d = 1'b1;
                    end else if (GAP_CYCLES > 0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
                    end else if (buf_nonempty) begin
                        emit = 1'b1;
                    end else begin
                        state_d = S_WAIT_ACQ;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
                    if (buf_nonempty) begin
                        state_d = S_STREAM;
                        emit    = 1'b1;
                    end else begin
                        state_d = S_WAIT_ACQ;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (emit) begin
            wr_en_d   = 1'b1;
            pix_idx_d = emit_pix;
            data_d    = head_pix[emit_pix];
            pop       = (emit_pix == PW'(PIXEL_NUM - 1));
        end

        if (abort) begin
            state_d      = S_IDLE;
            flush        = 1'b1;
            pop          = 1'b0;
            wr_en_d      = 1'b0;
            data_d       = '0;
            pix_idx_d    = '0;
            acq_idx_d    = '0;
            acc_cnt_d    = '0;
            frame_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q      <= S_IDLE;
            wr_en_q      <= 1'b0;
            data_q       <= '0;
            pix_idx_q    <= '0;
            acq_idx_q    <= '0;
            acc_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_en_q      <= wr_en_d;
            data_q       <= data_d;
            pix_idx_q    <= pix_idx_d;
            acq_idx_q    <= acq_idx_d;
            acc_cnt_q    <= acc_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign wrEn       = wr_en_q;
    assign data       = data_q;
    assign pix_idx    = pix_idx_q;
    assign acq_idx    = acq_idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_roughdata_sequencer.sv
// Scoreboard bench for roughdata_sequencer: accepted acquisitions are expanded
// into expected output words; a negedge monitor pops and compares them.
module tb_roughdata_sequencer;

    localparam int NP  = 10;
    localparam int PN  = 3;
    localparam int AN  = 2;
    localparam int GAP = 4;
    localparam int DW  = PN * NP;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          res, start, abort, acq_valid, acq_ready, wrEn, busy, frame_done;
    logic [DW-1:0] acq_data;
    logic [NP-1:0] data;
    logic [1:0]    pix_idx;
    logic [0:0]    acq_idx;

    logic          start1, abort1, acq_valid1, acq_ready1, wrEn1, busy1, frame_done1;
    logic [DW-1:0] acq_data1;
    logic [NP-1:0] data1;
    logic [1:0]    pix_idx1;
    logic [0:0]    acq_idx1;

    roughdata_sequencer #(.NP(NP), .PIXEL_NUM(PN), .ACQ_NUM(AN), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .res(res), .start(start), .abort(abort), .acq_valid(acq_valid),
        .acq_data(acq_data), .acq_ready(acq_ready), .wrEn(wrEn), .data(data),
        .pix_idx(pix_idx), .acq_idx(acq_idx), .busy(busy), .frame_done(frame_done)
    );

    roughdata_sequencer #(.NP(NP), .PIXEL_NUM(PN), .ACQ_NUM(AN), .GAP_CYCLES(0)) dut_nogap (
        .clk(clk), .res(res), .start(start1), .abort(abort1), .acq_valid(acq_valid1),
        .acq_data(acq_data1), .acq_ready(acq_ready1), .wrEn(wrEn1), .data(data1),
        .pix_idx(pix_idx1), .acq_idx(acq_idx1), .busy(busy1), .frame_done(frame_done1)
    );

    typedef struct { logic [NP-1:0] d; int pix; int acq; } word_t;
    typedef struct { int cyc; logic wr; logic [NP-1:0] d; logic fd; int pix; } trace_t;

    int     tests = 0;
    int     fails = 0;
    word_t  exp_q[$];
    trace_t trace_q[$];
    bit     log_en = 0;
    bit     frame_active = 0;
    int     acc_in_frame = 0;
    int     done_cnt = 0;
    int     idle_run = 0;
    int     cyc_n = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic void check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_n);
        end
    endfunction

    // Reference model: an accepted acquisition yields its pixels in ascending order.
    function automatic void model_accept(input logic [DW-1:0] v);
        check("accept_within_frame_limit", int'(acc_in_frame < AN), 1);
        for (int p = 0; p < PN; p++) exp_q.push_back('{v[p*NP +: NP], p, acc_in_frame});
        acc_in_frame++;
    endfunction

    function automatic logic [DW-1:0] pack3(input int a, input int b, input int c);
        return {NP'(c), NP'(b), NP'(a)};
    endfunction

    always @(negedge clk) begin : monitor
        word_t w;
        if (!res) begin
            if (log_en) trace_q.push_back('{cyc_n, wrEn, data, frame_done, int'(pix_idx)});
            if (wrEn) begin
                check("wr_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    check("data", data, w.d);
                    check("pix_idx", pix_idx, w.pix);
                    check("acq_idx", acq_idx, w.acq);
                    if (w.pix == 0 && w.acq != 0) check("gap_len_min", int'(idle_run >= GAP), 1);
                end
                idle_run = 0;
            end else begin
                check("data_zero_when_idle", data, 0);
                idle_run++;
            end
            if (frame_done) begin
                check("frame_done_expected", int'(frame_active && exp_q.size() == 0), 1);
                frame_active = 0;
                done_cnt++;
            end
        end
    end

    task automatic adv();
        @(negedge clk);
        #2;
    endtask

    task automatic tick(output bit accepted);
        accepted = acq_valid && acq_ready;
        if (accepted) model_accept(acq_data);
        adv();
    endtask

    task automatic begin_frame();
        bit a;
        start = 1'b1;
        frame_active = 1;
        acc_in_frame = 0;
        exp_q.delete();
        tick(a);
        start = 1'b0;
    endtask

    task automatic feed_frame(input logic [DW-1:0] vecs[$], input int max_delay, output int first_acc_cyc);
        int idx = 0;
        int budget = 0;
        int d0 = done_cnt;
        bit a;
        first_acc_cyc = -1;
        begin_frame();
        while (done_cnt == d0 && budget < 300) begin
            if (idx < vecs.size() && (acq_valid || $urandom_range(max_delay, 0) == 0)) begin
                acq_valid = 1'b1;
                acq_data  = vecs[idx];
            end else begin
                acq_valid = 1'b0;
            end
            if (acq_valid && acq_ready && first_acc_cyc < 0) first_acc_cyc = cyc_n;
            tick(a);
            if (a) begin
                idx++;
                acq_valid = 1'b0;
            end
            budget++;
        end
        acq_valid = 1'b0;
        check("frame_done_within_budget", done_cnt - d0, 1);
        check("accepted_per_frame", acc_in_frame, AN);
        tick(a);
        check("busy_after_done", busy, 0);
        check("ready_after_done", acq_ready, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [DW-1:0] vecs[$];
        logic [DW-1:0] va, vb, vc;
        int  acc_cyc, f, d0, run, exp_d[11];
        bit  a, found, seen, broke, fd1;

        res = 1'b1; start = 1'b0; abort = 1'b0; acq_valid = 1'b0; acq_data = '0;
        start1 = 1'b0; abort1 = 1'b0; acq_valid1 = 1'b0; acq_data1 = '0;
        repeat (3) adv();
        check("reset_wrEn", wrEn, 0);
        check("reset_data", data, 0);
        check("reset_idx", {pix_idx, acq_idx}, 0);
        check("reset_busy_ready_done", {busy, acq_ready, frame_done}, 0);
        check("reset_nogap_outputs", {wrEn1, data1, busy1, acq_ready1, frame_done1}, 0);
        res = 1'b0;
        adv();

        // Reference frame with exact timing
        va = pack3(108, 511, 1022);
        vb = pack3(200, 90, 1023);
        exp_d = '{108, 511, 1022, 0, 0, 0, 0, 200, 90, 1023, 0};
        trace_q.delete();
        log_en = 1;
        vecs = '{va, vb};
        feed_frame(vecs, 0, acc_cyc);
        log_en = 0;
        f = -1;
        foreach (trace_q[i]) if (f < 0 && trace_q[i].wr) f = i;
        check("first_word_seen", int'(f >= 0), 1);
        if (f >= 0) begin
            check("latency_accept_to_pixel0", trace_q[f].cyc - acc_cyc, 2);
            check("first_pix_idx", trace_q[f].pix, 0);
            check("trace_long_enough", int'(trace_q.size() >= f + 11), 1);
            for (int i = 0; i < 11 && f + i < trace_q.size(); i++) begin
                check("seq_wrEn", trace_q[f+i].wr, int'(i < 3 || (i >= 7 && i < 10)));
                check("seq_data", trace_q[f+i].d, exp_d[i]);
                check("seq_frame_done", trace_q[f+i].fd, int'(i == 10));
            end
        end

        // Third acquisition held valid must never be accepted
        vc = pack3(1, 2, 3);
        vecs = '{pack3(5, 6, 7), pack3(8, 9, 10), vc};
        feed_frame(vecs, 0, acc_cyc);

        // Randomised frames
        for (int r = 0; r < 12; r++) begin
            vecs.delete();
            for (int k = 0; k < AN + (($urandom_range(2, 0) == 0) ? 1 : 0); k++)
                vecs.push_back(pack3($urandom_range(1023, 0), $urandom_range(1023, 0), $urandom_range(1023, 0)));
            feed_frame(vecs, $urandom_range(3, 0), acc_cyc);
        end

        // Asynchronous reset during pixel 1 of acquisition 0
        begin_frame();
        acq_valid = 1'b1;
        acq_data  = va;
        tick(a);
        check("reset_test_accept", a, 1);
        acq_valid = 1'b0;
        tick(a);
        tick(a);
        check("pix1_before_reset", pix_idx, 1);
        res = 1'b1;
        #1;
        check("async_reset_wr_data", {wrEn, data}, 0);
        check("async_reset_idx", {pix_idx, acq_idx}, 0);
        check("async_reset_busy_ready_done", {busy, acq_ready, frame_done}, 0);
        exp_q.delete();
        frame_active = 0;
        acc_in_frame = 0;
        adv();
        res = 1'b0;
        repeat (4) adv();
        check("idle_until_new_start", busy, 0);
        vecs = '{pack3(300, 500, 50), pack3($urandom_range(1023, 0), 7, 9)};
        feed_frame(vecs, 0, acc_cyc);

        // Abort during the gap, with start asserted alongside
        d0 = done_cnt;
        begin_frame();
        acq_valid = 1'b1;
        acq_data  = va;
        tick(a);
        acq_data  = vb;
        tick(a);
        acq_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (busy && !wrEn && acq_idx == 1'b1) found = 1;
            else tick(a);
        end
        check("reached_gap", found, 1);
        abort = 1'b1;
        start = 1'b1;
        exp_q.delete();
        frame_active = 0;
        tick(a);
        abort = 1'b0;
        start = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ready", acq_ready, 0);
        check("abort_wrEn", wrEn, 0);
        repeat (8) tick(a);
        check("start_with_abort_ignored", busy, 0);
        check("no_frame_done_after_abort", done_cnt, d0);

        // Zero-gap instance: both acquisitions buffered stream back to back
        start1 = 1'b1;
        adv();
        start1 = 1'b0;
        acq_valid1 = 1'b1;
        acq_data1  = va;
        check("nogap_ready_a", acq_ready1, 1);
        adv();
        acq_data1 = vb;
        check("nogap_ready_b", acq_ready1, 1);
        adv();
        acq_valid1 = 1'b0;
        run = 0; seen = 0; broke = 0; fd1 = 0;
        for (int i = 0; i < 20; i++) begin
            if (frame_done1) fd1 = 1;
            if (wrEn1 && !broke) begin
                if (run < 6) begin
                    check("nogap_data", data1, (run < 3) ? va[(run % 3)*NP +: NP] : vb[(run % 3)*NP +: NP]);
                    check("nogap_acq_idx", acq_idx1, run / 3);
                    check("nogap_pix_idx", pix_idx1, run % 3);
                end
                run++;
                seen = 1;
            end else if (seen) begin
                broke = 1;
            end
            adv();
        end
        check("nogap_consecutive_words", run, 6);
        check("nogap_frame_done", fd1, 1);
        check("nogap_idle_at_end", busy1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
